// File: rtl/emitter_uart_pkg.sv
// Shared types and helpers for the buffered UART emitter.
// FSM state encoding, baud divisor and parameter sanity helpers.
package emitter_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int MIN_DIV   = 2;
    localparam int MIN_DEPTH = 2;
    localparam int MAX_DEPTH = 256;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/emitter_uart_fifo.sv
// Synchronous byte FIFO for the UART emitter.
// Extra pointer MSB separates full from empty; pointers wrap naturally.
module emitter_uart_fifo
    import emitter_uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                     (wptr[AW] != rptr[AW]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign level   = LW'(wptr - rptr);
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/emitter_uart_buffered.sv
// FIFO-buffered 8-bit UART emitter fed by an AXI-Stream byte port.
// Define EMITTER_UART_PARITY_EN to add an even parity bit after the data.
module emitter_uart_buffered
    import emitter_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 16_000_000,
    parameter int BAUD_RATE   = 57_600,
    parameter int DEPTH       = 16,
    parameter int STOP_BITS   = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [7:0]                 i_tdata,
    input  logic                       i_tlast,
    input  logic                       i_tvalid,
    output logic                       o_tready,
    output logic                       o_uart_tx,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic [15:0]                o_msgs
);

    localparam int DIV      = baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CW       = $clog2(STOP_LEN);
    localparam int LW       = $clog2(DEPTH + 1);

    localparam bit DIV_OK   = (DIV >= MIN_DIV);
    localparam bit DEPTH_OK = is_pow2(DEPTH) &&
                              (DEPTH >= MIN_DEPTH) &&
                              (DEPTH <= MAX_DEPTH);
    localparam bit STOP_OK  = (STOP_BITS == 1) || (STOP_BITS == 2);

    if (!DIV_OK) begin : g_bad_div
        $error("emitter_uart_buffered: baud divisor below 2");
    end
    if (!DEPTH_OK) begin : g_bad_depth
        $error("emitter_uart_buffered: DEPTH not a power of two in 2..256");
    end
    if (!STOP_OK) begin : g_bad_stop
        $error("emitter_uart_buffered: STOP_BITS must be 1 or 2");
    end

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     idx;
    logic [7:0]     shifter;
    logic           line_bit;
    logic           cnt_done;
    logic           push;
    logic           pop;
    logic [7:0]     fifo_dout;
    logic [LW-1:0]  fifo_level;
    logic [LW-1:0]  level_next;
    logic           fifo_full;
    logic           fifo_empty;
`ifdef EMITTER_UART_PARITY_EN
    logic           par_bit;
`endif

    assign push     = i_tvalid && o_tready && !fifo_full;
    assign cnt_done = (cnt == '0);
    assign pop      = !fifo_empty &&
                      ((state == IDLE) ||
                       ((state == STOP) && cnt_done));
    assign o_level  = fifo_level;

    emitter_uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .din   (i_tdata),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Occupancy after this edge, used to register the ready flag.
    always_comb begin
        level_next = fifo_level;
        if (push && !pop) level_next = fifo_level + 1'b1;
        if (pop && !push) level_next = fifo_level - 1'b1;
    end

    // Bit the line should carry for the current state.
    always_comb begin
        line_bit = 1'b1;
        unique case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shifter[0];
`ifdef EMITTER_UART_PARITY_EN
            PARITY:  line_bit = par_bit;
`endif
            default: line_bit = 1'b1;
        endcase
    end

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shifter   <= '0;
`ifdef EMITTER_UART_PARITY_EN
            par_bit   <= 1'b0;
`endif
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
        end else begin
            o_uart_tx <= line_bit;
            o_busy    <= (state != IDLE) || (fifo_level != '0);
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shifter <= fifo_dout;
`ifdef EMITTER_UART_PARITY_EN
                        par_bit <= ^fifo_dout;
`endif
                        cnt     <= CW'(DIV - 1);
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt_done) begin
                        cnt   <= CW'(DIV - 1);
                        idx   <= '0;
                        state <= DATA;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_done) begin
                        shifter <= shifter >> 1;
                        if (idx == 3'd7) begin
`ifdef EMITTER_UART_PARITY_EN
                            cnt   <= CW'(DIV - 1);
                            state <= PARITY;
`else
                            cnt   <= CW'(STOP_LEN - 1);
                            state <= STOP;
`endif
                        end else begin
                            cnt <= CW'(DIV - 1);
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef EMITTER_UART_PARITY_EN
                PARITY: begin
                    if (cnt_done) begin
                        cnt   <= CW'(STOP_LEN - 1);
                        state <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_done) begin
                        if (pop) begin
                            shifter <= fifo_dout;
`ifdef EMITTER_UART_PARITY_EN
                            par_bit <= ^fifo_dout;
`endif
                            cnt     <= CW'(DIV - 1);
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Message counter: one count per accepted end-of-message beat.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_msgs <= '0;
        end else if (push && i_tlast) begin
            o_msgs <= o_msgs + 16'd1;
        end
    end

    // Ready mirrors "not full" for the occupancy after this edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_tready <= 1'b0;
        end else begin
            o_tready <= (level_next != LW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_emitter_uart_buffered.sv
// Directed bench for emitter_uart_buffered (DIV=16, DEPTH=4).
// A second instance with two stop bits covers the 8N2 framing.
module tb_emitter_uart_buffered;

`ifdef EMITTER_UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int F1 = 16 * (10 + PB);
    localparam int F2 = 16 * (11 + PB);

    logic       clk;
    logic       rst_n;
    logic [7:0] tdata, tdata2;
    logic       tlast, tlast2;
    logic       tvalid, tvalid2;
    logic       tready, tready2;
    logic       tx, tx2;
    logic       busy, busy2;
    logic [2:0] level, level2;
    logic [15:0] msgs, msgs2;

    int compared;
    int mismatched;
    int cyc;

    emitter_uart_buffered #(
        .CLK_FREQ_HZ (16_000_000),
        .BAUD_RATE   (1_000_000),
        .DEPTH       (4),
        .STOP_BITS   (1)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tdata   (tdata),
        .i_tlast   (tlast),
        .i_tvalid  (tvalid),
        .o_tready  (tready),
        .o_uart_tx (tx),
        .o_busy    (busy),
        .o_level   (level),
        .o_msgs    (msgs)
    );

    emitter_uart_buffered #(
        .CLK_FREQ_HZ (16_000_000),
        .BAUD_RATE   (1_000_000),
        .DEPTH       (4),
        .STOP_BITS   (2)
    ) dut2 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tdata   (tdata2),
        .i_tlast   (tlast2),
        .i_tvalid  (tvalid2),
        .o_tready  (tready2),
        .o_uart_tx (tx2),
        .o_busy    (busy2),
        .o_level   (level2),
        .o_msgs    (msgs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic send(input bit sel, input logic [7:0] d,
                        input logic last, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clk);
        if (sel) begin
            tvalid2 = 1'b1; tdata2 = d; tlast2 = last;
        end else begin
            tvalid = 1'b1; tdata = d; tlast = last;
        end
        while (!(sel ? tready2 : tready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (!(sel ? tready2 : tready)) begin
            mismatched++;
            $display("FAIL tready_timeout: tready=0 required 1");
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic check_frame(input bit sel, input logic [7:0] exp,
                               input int nstop, output int st);
        int n;
        logic [7:0] got;
        n = 0;
        st = -1;
        while ((sel ? tx2 : tx) !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if ((sel ? tx2 : tx) !== 1'b0) begin
            mismatched++;
            $display("FAIL start_timeout: tx=%b required 0",
                     sel ? tx2 : tx);
            return;
        end
        st = cyc;
        repeat (8) @(negedge clk);
        compared++;
        if ((sel ? tx2 : tx) !== 1'b0) begin
            mismatched++;
            $display("FAIL start_bit: tx=%b required 0", sel ? tx2 : tx);
        end
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            got[i] = sel ? tx2 : tx;
        end
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL data_bits: got %h required %h", got, exp);
        end
`ifdef EMITTER_UART_PARITY_EN
        repeat (16) @(negedge clk);
        compared++;
        if ((sel ? tx2 : tx) !== ^exp) begin
            mismatched++;
            $display("FAIL parity_bit: tx=%b required %b",
                     sel ? tx2 : tx, ^exp);
        end
`endif
        for (int s = 0; s < nstop; s++) begin
            repeat (16) @(negedge clk);
            compared++;
            if ((sel ? tx2 : tx) !== 1'b1) begin
                mismatched++;
                $display("FAIL stop_bit%0d: tx=%b required 1", s,
                         sel ? tx2 : tx);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tvalid = 1'b1;
        tdata = 8'hAA;
        tlast = 1'b1;
        repeat (5) begin
            @(negedge clk);
            compared++;
            if (tx !== 1'b1 || tready !== 1'b0 || level !== 3'd0 ||
                busy !== 1'b0 || msgs !== 16'd0) begin
                mismatched++;
                $display("FAIL reset_state: tx=%b rdy=%b lvl=%0d bsy=%b msgs=%0d required 1 0 0 0 0",
                         tx, tready, level, busy, msgs);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (tready !== 1'b1 || level !== 3'd0 || msgs !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_release: rdy=%b lvl=%0d msgs=%0d required 1 0 0",
                     tready, level, msgs);
        end
        tvalid = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic test_single();
        int n;
        int st;
        send(0, 8'h55, 1'b0, n);
        @(negedge clk);
        tvalid = 1'b0;
        compared++;
        if (level !== 3'd1) begin
            mismatched++;
            $display("FAIL single_level: lvl=%0d required 1", level);
        end
        @(negedge clk);
        compared++;
        if (tx !== 1'b1 || level !== 3'd0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL single_pop: tx=%b lvl=%0d bsy=%b required 1 0 1",
                     tx, level, busy);
        end
        check_frame(0, 8'h55, 1, st);
        compared++;
        if (st !== n + 2) begin
            mismatched++;
            $display("FAIL single_latency: start=%0d required %0d", st, n + 2);
        end
        while (cyc < n + 1 + F1) @(negedge clk);
        compared++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            mismatched++;
            $display("FAIL single_busy_end: bsy=%b tx=%b required 1 1", busy, tx);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            mismatched++;
            $display("FAIL single_busy_fall: bsy=%b tx=%b required 0 1", busy, tx);
        end
    endtask

    task automatic test_back_to_back();
        int acc0;
        int first;
        int last;
        int peak;
        bit stalled;
        peak = 0;
        stalled = 1'b0;
        first = -1;
        last = -1;
        acc0 = -1;
        fork
            begin
                int a;
                for (int i = 0; i < 6; i++) begin
                    send(0, 8'(i), 1'b0, a);
                    if (i == 0) acc0 = a;
                end
                @(negedge clk);
                tvalid = 1'b0;
            end
            begin
                int st;
                for (int i = 0; i < 6; i++) begin
                    check_frame(0, 8'(i), 1, st);
                    if (i == 0) first = st;
                    if (i == 5) last = st;
                end
            end
            begin
                repeat (1100) begin
                    @(negedge clk);
                    if (int'(level) > peak) peak = int'(level);
                    if (tvalid && !tready) stalled = 1'b1;
                end
            end
        join
        compared++;
        if (first !== acc0 + 2) begin
            mismatched++;
            $display("FAIL burst_latency: start=%0d required %0d", first, acc0 + 2);
        end
        compared++;
        if (last - first !== 5 * F1) begin
            mismatched++;
            $display("FAIL burst_gapless: span=%0d required %0d",
                     last - first, 5 * F1);
        end
        compared++;
        if (peak !== 4 || stalled !== 1'b1) begin
            mismatched++;
            $display("FAIL burst_full: peak=%0d stall=%b required 4 1", peak, stalled);
        end
        compared++;
        if (busy !== 1'b0 || level !== 3'd0) begin
            mismatched++;
            $display("FAIL burst_drain: bsy=%b lvl=%0d required 0 0", busy, level);
        end
    endtask

    task automatic test_stop2();
        int s0;
        int s1;
        s0 = -1;
        s1 = -1;
        fork
            begin
                int a;
                send(1, 8'hC3, 1'b0, a);
                send(1, 8'h0F, 1'b0, a);
                @(negedge clk);
                tvalid2 = 1'b0;
            end
            begin
                check_frame(1, 8'hC3, 2, s0);
                check_frame(1, 8'h0F, 2, s1);
            end
        join
        compared++;
        if (s1 - s0 !== F2) begin
            mismatched++;
            $display("FAIL stop2_spacing: span=%0d required %0d", s1 - s0, F2);
        end
    endtask

`ifdef EMITTER_UART_PARITY_EN
    task automatic test_parity();
        int s0;
        int s1;
        s0 = -1;
        s1 = -1;
        fork
            begin
                int a;
                send(0, 8'h07, 1'b0, a);
                send(0, 8'h55, 1'b0, a);
                @(negedge clk);
                tvalid = 1'b0;
            end
            begin
                check_frame(0, 8'h07, 1, s0);
                check_frame(0, 8'h55, 1, s1);
            end
        join
        compared++;
        if (s1 - s0 !== 176) begin
            mismatched++;
            $display("FAIL parity_frame: span=%0d required 176", s1 - s0);
        end
    endtask
`endif

    task automatic test_mid_reset();
        int a;
        int n;
        send(0, 8'hA5, 1'b1, a);
        send(0, 8'h5A, 1'b1, a);
        @(negedge clk);
        tvalid = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        a = cyc;
        while (cyc < a + 50) @(negedge clk);
        compared++;
        if (msgs !== 16'd2 || level !== 3'd1) begin
            mismatched++;
            $display("FAIL pre_reset: msgs=%0d lvl=%0d required 2 1", msgs, level);
        end
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if (tx !== 1'b1 || level !== 3'd0 || msgs !== 16'd0 ||
            busy !== 1'b0 || tready !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset: tx=%b lvl=%0d msgs=%0d bsy=%b rdy=%b required 1 0 0 0 0",
                     tx, level, msgs, busy, tready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        fork
            begin
                int b;
                send(0, 8'h3C, 1'b1, b);
                send(0, 8'hC3, 1'b1, b);
                send(0, 8'h81, 1'b0, b);
                send(0, 8'h7E, 1'b1, b);
                @(negedge clk);
                tvalid = 1'b0;
                tlast = 1'b0;
            end
            begin
                int st;
                check_frame(0, 8'h3C, 1, st);
                check_frame(0, 8'hC3, 1, st);
                check_frame(0, 8'h81, 1, st);
                check_frame(0, 8'h7E, 1, st);
            end
        join
        compared++;
        if (msgs !== 16'd3) begin
            mismatched++;
            $display("FAIL msg_count: msgs=%0d required 3", msgs);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        cyc = 0;
        rst_n = 1'b0;
        tvalid = 1'b0;
        tdata = 8'h00;
        tlast = 1'b0;
        tvalid2 = 1'b0;
        tdata2 = 8'h00;
        tlast2 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stop2();
`ifdef EMITTER_UART_PARITY_EN
        test_parity();
`endif
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
